// File: rtl/qos_id_alloc_pkg.sv
// Shared types for the QoS ID allocator slice.
// ID, QoS widths and allocator FSM encoding.
package qos_pkg;
   localparam int NUM_ID = 16;
   localparam int ID_W   = 4;
   localparam int QOS_W  = 3;

   typedef logic [QOS_W-1:0] qos_t;
   typedef logic [ID_W-1:0]  id_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DONE
   } alloc_state_t;
endpackage

// File: rtl/qos_id_alloc_if.sv
// Request/completion handshake and tracker strobes
// between an initiator and the ID allocator.
interface qos_id_alloc_if;
   logic          req_vld;
   qos_pkg::qos_t req_qos;
   logic          req_rdy;
   qos_pkg::id_t  alloc_id;
   logic          cpl_vld;
   qos_pkg::id_t  cpl_id;
   logic          wr_vld;
   qos_pkg::id_t  wr_id;
   qos_pkg::qos_t wr_qos;
   logic          rd_vld;
   qos_pkg::id_t  rd_id;

   modport master (
      output req_vld, req_qos, cpl_vld, cpl_id,
      input  req_rdy, alloc_id,
      input  wr_vld, wr_id, wr_qos, rd_vld, rd_id
   );

   modport slave (
      input  req_vld, req_qos, cpl_vld, cpl_id,
      output req_rdy, alloc_id,
      output wr_vld, wr_id, wr_qos, rd_vld, rd_id
   );
endinterface

// File: rtl/qos_id_alloc_ffs_enc.sv
// Lowest-set-bit encoder: index of the first 1 in vec
// plus a found flag.
module ffs_enc #(
   parameter int W  = 16,
   parameter int IW = 4
) (
   input  logic [W-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          found
);
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = i[IW-1:0];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/qos_id_alloc.sv
// QoS-aware transaction ID allocator with drain handshake.
// Define QOS_ID_ALLOC_CHECK_EN to add the sticky err output.
module qos_id_alloc
   import qos_pkg::*;
#(
   parameter int RESERVE = 2,
   parameter int HI_QOS  = 4
) (
   input  logic          clk,
   input  logic          rst,
   qos_id_alloc_if.slave bus,
   output logic [ID_W:0] free_cnt,
   input  logic          drain_req,
   output logic          drain_done
`ifdef QOS_ID_ALLOC_CHECK_EN
   ,
   output logic          err
`endif
);
   localparam logic [ID_W:0] CNT_FULL = NUM_ID[ID_W:0];
   localparam logic [ID_W:0] CNT_RES  = RESERVE[ID_W:0];
   localparam qos_t          QOS_HI   = HI_QOS[QOS_W-1:0];

   alloc_state_t      state_q;
   logic              drain_done_q;
   logic [NUM_ID-1:0] busy_q, busy_d;
   logic [NUM_ID-1:0] free_vec;
   logic [ID_W:0]     free_cnt_q, free_cnt_d;
   logic              wr_vld_q, wr_vld_d;
   id_t               wr_id_q, wr_id_d;
   qos_t              wr_qos_q, wr_qos_d;
   logic              rd_vld_q, rd_vld_d;
   id_t               rd_id_q, rd_id_d;
   id_t               ffs_idx;
   logic              ffs_found;
   logic              req_rdy;
   logic              accept;
   logic              cpl_ok;

   assign free_vec = ~busy_q;

   ffs_enc #(
      .W  (NUM_ID),
      .IW (ID_W)
   ) u_ffs (
      .vec   (free_vec),
      .idx   (ffs_idx),
      .found (ffs_found)
   );

   // Low-QoS traffic may not dip into the reserved tail of the pool.
   assign req_rdy = (state_q == RUN) && ffs_found &&
                    (free_cnt_q != '0) &&
                    ((free_cnt_q > CNT_RES) ||
                     (bus.req_qos >= QOS_HI));

   assign bus.req_rdy  = req_rdy;
   assign bus.alloc_id = ffs_idx;
   assign bus.wr_vld   = wr_vld_q;
   assign bus.wr_id    = wr_id_q;
   assign bus.wr_qos   = wr_qos_q;
   assign bus.rd_vld   = rd_vld_q;
   assign bus.rd_id    = rd_id_q;
   assign free_cnt     = free_cnt_q;
   assign drain_done   = drain_done_q;

   always_comb begin
      accept = bus.req_vld && req_rdy;
      cpl_ok = bus.cpl_vld && busy_q[bus.cpl_id];
      busy_d = busy_q;
      if (accept) busy_d[ffs_idx] = 1'b1;
      if (cpl_ok) busy_d[bus.cpl_id] = 1'b0;
      free_cnt_d = free_cnt_q
                 - {{ID_W{1'b0}}, accept}
                 + {{ID_W{1'b0}}, cpl_ok};
      wr_vld_d = accept;
      wr_id_d  = accept ? ffs_idx : wr_id_q;
      wr_qos_d = accept ? bus.req_qos : wr_qos_q;
      rd_vld_d = cpl_ok;
      rd_id_d  = cpl_ok ? bus.cpl_id : rd_id_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= '0;
         free_cnt_q <= CNT_FULL;
         wr_vld_q   <= 1'b0;
         wr_id_q    <= '0;
         wr_qos_q   <= '0;
         rd_vld_q   <= 1'b0;
         rd_id_q    <= '0;
      end else begin
         busy_q     <= busy_d;
         free_cnt_q <= free_cnt_d;
         wr_vld_q   <= wr_vld_d;
         wr_id_q    <= wr_id_d;
         wr_qos_q   <= wr_qos_d;
         rd_vld_q   <= rd_vld_d;
         rd_id_q    <= rd_id_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         drain_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (drain_req) state_q <= DRAIN;
            end
            DRAIN: begin
               if (!drain_req) begin
                  state_q <= RUN;
               end else if (free_cnt_q == CNT_FULL) begin
                  state_q      <= DONE;
                  drain_done_q <= 1'b1;
               end
            end
            DONE: begin
               if (!drain_req) begin
                  state_q      <= RUN;
                  drain_done_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= RUN;
               drain_done_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef QOS_ID_ALLOC_CHECK_EN
   logic err_q, err_d;
   logic hold_q, hold_d;
   qos_t qos_q, qos_d;

   // A stalled request must keep its QoS stable until accepted.
   always_comb begin
      hold_d = bus.req_vld && !req_rdy;
      qos_d  = bus.req_qos;
      err_d  = err_q ||
               (bus.cpl_vld && !busy_q[bus.cpl_id]) ||
               (hold_q && bus.req_vld &&
                (bus.req_qos != qos_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q  <= 1'b0;
         hold_q <= 1'b0;
         qos_q  <= '0;
      end else begin
         err_q  <= err_d;
         hold_q <= hold_d;
         qos_q  <= qos_d;
      end
   end

   assign err = err_q;

   a_cnt_match : assert property (
      @(posedge clk) disable iff (rst)
      int'(free_cnt_q) == $countones(free_vec)
   );
`endif
endmodule

// File: tb/tb_qos_id_alloc.sv
// Directed and randomized checks of qos_id_alloc against
// a free-set reference model.
module tb_qos_id_alloc;
   import qos_pkg::*;

   localparam int RES = 2;
   localparam int HI  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [ID_W:0] free_cnt;
   logic          drain_req;
   logic          drain_done;
`ifdef QOS_ID_ALLOC_CHECK_EN
   logic          err;
`endif

   qos_id_alloc_if bus ();

   qos_id_alloc u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .free_cnt   (free_cnt),
      .drain_req  (drain_req),
      .drain_done (drain_done)
`ifdef QOS_ID_ALLOC_CHECK_EN
      ,
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: which IDs are in flight, plus drain mode.
   bit m_busy[NUM_ID];
   int m_mode;
   bit m_err;
   bit m_hold;
   int m_prevq;

   bit a;
   int id;
   bit dr_r;

   function automatic int m_free();
      int n = 0;
      for (int i = 0; i < NUM_ID; i++)
         if (!m_busy[i]) n++;
      return n;
   endfunction

   function automatic int m_lowest();
      for (int i = 0; i < NUM_ID; i++)
         if (!m_busy[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NUM_ID; i++) m_busy[i] = 1'b0;
      m_mode  = 0;
      m_err   = 1'b0;
      m_hold  = 1'b0;
      m_prevq = 0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.req_vld = 1'b0;
      bus.req_qos = '0;
      bus.cpl_vld = 1'b0;
      bus.cpl_id  = '0;
      drain_req   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      chk("rst_wr_vld", bus.wr_vld, 0);
      chk("rst_wr_id", bus.wr_id, 0);
      chk("rst_wr_qos", bus.wr_qos, 0);
      chk("rst_rd_vld", bus.rd_vld, 0);
      chk("rst_rd_id", bus.rd_id, 0);
      chk("rst_free_cnt", free_cnt, NUM_ID);
      chk("rst_drain_done", drain_done, 0);
      chk("rst_req_rdy", bus.req_rdy, 1);
`ifdef QOS_ID_ALLOC_CHECK_EN
      chk("rst_err", err, 0);
`endif
      rst = 1'b0;
   endtask

   // One clock of stimulus; checks comb outputs, then registered.
   task automatic cycle(input bit rv, input int rq,
                        input bit cv, input int ci,
                        input bit dr,
                        output bit acc, output int got);
      bit rdy_e;
      bit cok;
      int fc;
      int lo;
      bus.req_vld = rv;
      bus.req_qos = qos_t'(rq);
      bus.cpl_vld = cv;
      bus.cpl_id  = id_t'(ci);
      drain_req   = dr;
      #1;
      fc    = m_free();
      lo    = m_lowest();
      rdy_e = (m_mode == 0) && (fc != 0) &&
              ((fc > RES) || (rq >= HI));
      chk("req_rdy", bus.req_rdy, rdy_e);
      if (fc != 0) chk("alloc_id", bus.alloc_id, lo);
      acc = rv && bus.req_rdy;
      got = int'(bus.alloc_id);
      cok = cv && m_busy[ci];
      if (cv && !m_busy[ci]) m_err = 1'b1;
      if (m_hold && rv && (rq != m_prevq)) m_err = 1'b1;
      m_hold  = rv && !rdy_e;
      m_prevq = rq;
      case (m_mode)
         0: if (dr) m_mode = 1;
         1: if (!dr) m_mode = 0;
            else if (fc == NUM_ID) m_mode = 2;
         default: if (!dr) m_mode = 0;
      endcase
      if (rv && rdy_e) m_busy[lo] = 1'b1;
      if (cok) m_busy[ci] = 1'b0;
      @(posedge clk);
      #1;
      chk("wr_vld", bus.wr_vld, rv && rdy_e);
      if (rv && rdy_e) begin
         chk("wr_id", bus.wr_id, lo);
         chk("wr_qos", bus.wr_qos, rq);
      end
      chk("rd_vld", bus.rd_vld, cok);
      if (cok) chk("rd_id", bus.rd_id, ci);
      chk("free_cnt", free_cnt, m_free());
      chk("drain_done", drain_done, m_mode == 2);
`ifdef QOS_ID_ALLOC_CHECK_EN
      chk("err", err, m_err);
`endif
   endtask

   initial begin
      do_reset();

      cycle(1, 1, 0, 0, 0, a, id);
      chk("seq_id0", id, 0);
      cycle(1, 5, 0, 0, 0, a, id);
      chk("seq_id1", id, 1);
      cycle(1, 2, 0, 0, 0, a, id);
      chk("seq_id2", id, 2);
      chk("seq_free13", free_cnt, 13);

      for (int i = 0; i < 11; i++) cycle(1, 1, 0, 0, 0, a, id);
      chk("fill_free2", free_cnt, 2);
      cycle(1, 1, 0, 0, 0, a, id);
      chk("low_qos_stall", a, 0);
      cycle(0, 0, 0, 0, 0, a, id);
      cycle(1, 4, 0, 0, 0, a, id);
      chk("hi4_acc", a, 1);
      chk("hi4_id14", id, 14);
      cycle(1, 7, 0, 0, 0, a, id);
      chk("hi7_id15", id, 15);
      cycle(1, 7, 0, 0, 0, a, id);
      chk("empty_stall", a, 0);
      chk("empty_free0", free_cnt, 0);

      cycle(0, 0, 1, 5, 0, a, id);
      cycle(1, 7, 1, 1, 0, a, id);
      chk("pre_update_id", id, 5);
      chk("cpl1_rd_vld", bus.rd_vld, 1);
      chk("cpl1_rd_id", bus.rd_id, 1);
      cycle(1, 7, 0, 0, 0, a, id);
      chk("reuse_id1", id, 1);

      for (int i = 0; i < 10; i++) cycle(0, 0, 1, i, 0, a, id);
      chk("sim_pre_free10", free_cnt, 10);
      cycle(1, 1, 1, 12, 0, a, id);
      chk("sim_acc", a, 1);
      chk("sim_free10", free_cnt, 10);
      chk("sim_wr_vld", bus.wr_vld, 1);
      chk("sim_rd_vld", bus.rd_vld, 1);

      do_reset();
      cycle(1, 2, 0, 0, 0, a, id);
      cycle(1, 2, 0, 0, 0, a, id);
      cycle(1, 7, 0, 0, 1, a, id);
      chk("drain_edge_acc", a, 1);
      chk("drain_edge_id", id, 2);
      cycle(1, 7, 0, 0, 1, a, id);
      chk("drain_stall0", a, 0);
      cycle(1, 7, 1, 0, 1, a, id);
      chk("drain_stall1", a, 0);
      cycle(1, 7, 1, 1, 1, a, id);
      chk("drain_stall2", a, 0);
      cycle(1, 7, 1, 2, 1, a, id);
      chk("drain_stall3", a, 0);
      chk("drain_free16", free_cnt, NUM_ID);
      chk("drain_not_yet", drain_done, 0);
      cycle(1, 7, 0, 0, 1, a, id);
      chk("drain_done_up", drain_done, 1);
      cycle(0, 0, 0, 0, 0, a, id);
      chk("drain_done_dn", drain_done, 0);
      cycle(1, 3, 0, 0, 0, a, id);
      chk("run_again", a, 1);

      do_reset();
      cycle(0, 0, 1, 9, 0, a, id);
      chk("bad_cpl_rd_vld", bus.rd_vld, 0);
      chk("bad_cpl_free", free_cnt, NUM_ID);
`ifdef QOS_ID_ALLOC_CHECK_EN
      chk("bad_cpl_err", err, 1);
      cycle(0, 0, 0, 0, 0, a, id);
      cycle(0, 0, 0, 0, 0, a, id);
      chk("err_sticky", err, 1);
`endif
      do_reset();

      dr_r = 1'b0;
      for (int n = 0; n < 400; n++) begin
         int ci;
         if ($urandom_range(0, 15) == 0) dr_r = !dr_r;
         ci = $urandom_range(0, NUM_ID - 1);
         for (int t = 0; t < 4 && !m_busy[ci]; t++)
            ci = $urandom_range(0, NUM_ID - 1);
         cycle($urandom_range(0, 3) != 0,
               $urandom_range(0, 7),
               $urandom_range(0, 2) == 0,
               ci, dr_r, a, id);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
